// File: rtl/sram_port_arbiter.sv
// Purpose: shares one SRAM-like bus port between the fetch (inst) and data requesters, routing responses in order.
// Latency: grant and addr_ok are combinational; responses pass through with zero added cycles.
// Backpressure: requesters hold until addr_ok; no grant while MAX_OUT transactions are outstanding.
// Optional feature macro: ARB_RR_EN (round-robin arbitration; fixed data-over-inst priority when undefined).

// Generic synchronous FIFO with occupancy count; the caller never pushes when full or pops when empty.
module sram_arb_fifo #(
  parameter int DW = 2,
  parameter int AW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_dat,
  input  logic          pop,
  output logic [DW-1:0] pop_dat,
  output logic [AW:0]   count
);

  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // storage write; contents need no reset because count qualifies them
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  // pointers wrap naturally at 2**AW; simultaneous push and pop keep count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop_dat = mem[rd_ptr];

endmodule

// Top-level arbiter.
module sram_port_arbiter #(
  parameter int MAX_OUT = 2,
  parameter int TAG_AW  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        stallreq_if,
  output logic        stallreq_mem,
  output logic [2:0]  outstanding,
  output logic        resp_err
);

  localparam int            CW      = TAG_AW + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

  logic [CW-1:0] fifo_cnt;
  logic [CW-1:0] rd_cnt;
  logic [1:0]    head;      // {is_data_read, tag}; tag 0 = inst, 1 = data
  logic [1:0]    push_dat;
  logic          full;
  logic          empty;
  logic          sel_data;
  logic          grant_any;
  logic          accept;
  logic          pop;
  logic          rd_pending;

  assign full  = (fifo_cnt == MAX_CNT);
  assign empty = (fifo_cnt == '0);

`ifdef ARB_RR_EN
  logic rr_ptr;  // 0 = inst has the turn, 1 = data has the turn

  // contention goes to whichever requester the pointer names
  always_comb begin
    sel_data = data_req & (~inst_req | rr_ptr);
  end

  // after any accepted grant the turn passes to the other requester
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rr_ptr <= 1'b0;
    else if (accept) rr_ptr <= ~sel_data;
  end
`else
  // data side always wins over fetch
  always_comb begin
    sel_data = data_req;
  end
`endif

  // full is judged on registered occupancy, so a same-cycle pop cannot unblock a grant
  assign grant_any = (inst_req | data_req) & ~full;
  assign accept    = grant_any & bus_addr_ok;

  // drive the bus from the winner; everything is zero when nothing is granted
  always_comb begin
    bus_req   = 1'b0;
    bus_wr    = 1'b0;
    bus_wstrb = 4'b0000;
    bus_addr  = 32'h0;
    bus_wdata = 32'h0;
    if (grant_any) begin
      bus_req = 1'b1;
      if (sel_data) begin
        bus_wr    = data_wr;
        bus_wstrb = data_wr ? data_wstrb : 4'b0000;
        bus_addr  = data_addr;
        bus_wdata = data_wr ? data_wdata : 32'h0;
      end else begin
        bus_addr  = inst_addr;
      end
    end
  end

  assign inst_addr_ok = accept & ~sel_data;
  assign data_addr_ok = accept &  sel_data;

  assign push_dat = {sel_data & ~data_wr, sel_data};
  assign pop      = bus_data_ok & ~empty;

  sram_arb_fifo #(
    .DW (2),
    .AW (TAG_AW)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (accept),
    .push_dat (push_dat),
    .pop      (pop),
    .pop_dat  (head),
    .count    (fifo_cnt)
  );

  assign inst_data_ok = pop & ~head[0];
  assign data_data_ok = pop &  head[0];
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;
  assign outstanding  = 3'(fifo_cnt);

  // count of data reads still awaiting their response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt <= '0;
    end else begin
      case ({accept & push_dat[1], pop & head[1]})
        2'b10:   rd_cnt <= rd_cnt + 1'b1;
        2'b01:   rd_cnt <= rd_cnt - 1'b1;
        default: rd_cnt <= rd_cnt;
      endcase
    end
  end

  // a read answered in this cycle no longer holds the memory stage
  always_comb begin
    rd_pending = 1'b0;
    if (rd_cnt > CW'(1))
      rd_pending = 1'b1;
    else if (rd_cnt == CW'(1))
      rd_pending = ~(pop & head[1]);
  end

  assign stallreq_if  = inst_req & ~inst_addr_ok;
  assign stallreq_mem = (data_req & ~data_addr_ok) | rd_pending;

  // a response with nothing outstanding is dropped and flagged until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       resp_err <= 1'b0;
    else if (bus_data_ok & empty)  resp_err <= 1'b1;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter (default parameters MAX_OUT = 2, TAG_AW = 1).
// Inputs change on the falling edge; outputs are sampled 1 ns later, well away from the rising edge.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req;
  logic        bus_wr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
  logic        stallreq_if;
  logic        stallreq_mem;
  logic [2:0]  outstanding;
  logic        resp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.MAX_OUT(2), .TAG_AW(1)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
    .outstanding(outstanding), .resp_err(resp_err)
  );

  task automatic idle_inputs();
    inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0; data_wstrb = 0;
    data_addr = 0; data_wdata = 0; bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
  endtask

  // advance one cycle: through the rising edge to the next falling edge
  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1;
    next_cycle();
    rst = 0;
  endtask

  task automatic test_reset();
    @(negedge clk); settle();
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL reset_outstanding got %0d exp 0", outstanding); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got %b exp 0", resp_err); end
    checks++; if ({bus_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, stallreq_if, stallreq_mem} !== 7'b0)
      begin errors++; $display("FAIL reset_ctrl_outputs got %b exp 0000000", {bus_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, stallreq_if, stallreq_mem}); end
    checks++; if ({bus_wr, bus_wstrb, bus_addr, bus_wdata} !== 69'h0) begin errors++; $display("FAIL reset_bus_outputs got %h exp 0", {bus_wr, bus_wstrb, bus_addr, bus_wdata}); end
  endtask

  task automatic test_single_fetch();
    do_reset();
    inst_req = 1; inst_addr = 32'hBFC00000; bus_addr_ok = 1; settle();
    checks++; if (bus_req !== 1'b1 || bus_addr !== 32'hBFC00000 || bus_wr !== 1'b0) begin errors++; $display("FAIL fetch_bus got req %b addr %h wr %b exp 1 bfc00000 0", bus_req, bus_addr, bus_wr); end
    checks++; if (inst_addr_ok !== 1'b1 || stallreq_if !== 1'b0) begin errors++; $display("FAIL fetch_addr_ok got ok %b stall %b exp 1 0", inst_addr_ok, stallreq_if); end
    next_cycle();
    inst_req = 0; bus_addr_ok = 0; settle();
    checks++; if (outstanding !== 3'd1 || inst_data_ok !== 1'b0) begin errors++; $display("FAIL fetch_wait got out %0d dok %b exp 1 0", outstanding, inst_data_ok); end
    next_cycle();
    bus_data_ok = 1; bus_rdata = 32'h3C080001; settle();
    checks++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0 || inst_rdata !== 32'h3C080001)
      begin errors++; $display("FAIL fetch_resp got idok %b ddok %b rdata %h exp 1 0 3c080001", inst_data_ok, data_data_ok, inst_rdata); end
    next_cycle();
    bus_data_ok = 0; bus_rdata = 0; settle();
    checks++; if (outstanding !== 3'd0 || inst_data_ok !== 1'b0) begin errors++; $display("FAIL fetch_done got out %0d dok %b exp 0 0", outstanding, inst_data_ok); end
  endtask

  task automatic test_priority();
    do_reset();
    inst_req = 1; inst_addr = 32'hBFC00004;
    data_req = 1; data_wr = 0; data_wstrb = 4'hF; data_addr = 32'h80001000; bus_addr_ok = 1; settle();
    checks++; if (bus_addr !== 32'h80001000 || data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0)
      begin errors++; $display("FAIL prio_first got addr %h dok %b iok %b exp 80001000 1 0", bus_addr, data_addr_ok, inst_addr_ok); end
    checks++; if (stallreq_if !== 1'b1 || bus_wstrb !== 4'b0000) begin errors++; $display("FAIL prio_stall_strb got stall %b strb %b exp 1 0000", stallreq_if, bus_wstrb); end
    next_cycle();
    data_req = 0; settle();
    checks++; if (bus_addr !== 32'hBFC00004 || inst_addr_ok !== 1'b1 || stallreq_if !== 1'b0)
      begin errors++; $display("FAIL prio_second got addr %h iok %b stall %b exp bfc00004 1 0", bus_addr, inst_addr_ok, stallreq_if); end
    checks++; if (stallreq_mem !== 1'b1 || outstanding !== 3'd1) begin errors++; $display("FAIL prio_rd_stall got stall %b out %0d exp 1 1", stallreq_mem, outstanding); end
    next_cycle();
    inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'hD0D0_0001; settle();
    checks++; if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0 || data_rdata !== 32'hD0D00001)
      begin errors++; $display("FAIL prio_resp1 got ddok %b idok %b rdata %h exp 1 0 d0d00001", data_data_ok, inst_data_ok, data_rdata); end
    next_cycle();
    bus_rdata = 32'h1111_2222; settle();
    checks++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0 || inst_rdata !== 32'h11112222)
      begin errors++; $display("FAIL prio_resp2 got idok %b ddok %b rdata %h exp 1 0 11112222", inst_data_ok, data_data_ok, inst_rdata); end
    next_cycle();
    idle_inputs(); settle();
    checks++; if (outstanding !== 3'd0 || stallreq_mem !== 1'b0) begin errors++; $display("FAIL prio_done got out %0d stall %b exp 0 0", outstanding, stallreq_mem); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_grant [4];
    exp_grant[0] = 2'b01; exp_grant[1] = 2'b10; exp_grant[2] = 2'b01; exp_grant[3] = 2'b10;
    do_reset();
    inst_req = 1; inst_addr = 32'hBFC00000; data_req = 1; data_addr = 32'h80000000; bus_addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      bus_data_ok = (i != 0); settle();
      checks++; if ({data_addr_ok, inst_addr_ok} !== exp_grant[i]) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", i, {data_addr_ok, inst_addr_ok}, exp_grant[i]); end
      next_cycle();
    end
    inst_req = 0; data_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
    next_cycle();
    next_cycle();
    bus_data_ok = 0; settle();
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL rr_drain got %0d exp 0", outstanding); end
  endtask

  task automatic test_max_outstanding();
    do_reset();
    inst_req = 1; inst_addr = 32'hBFC00010; bus_addr_ok = 1;
    next_cycle();
    next_cycle();
    settle();
    checks++; if (bus_req !== 1'b0 || outstanding !== 3'd2 || inst_addr_ok !== 1'b0 || stallreq_if !== 1'b1)
      begin errors++; $display("FAIL full_block got req %b out %0d iok %b stall %b exp 0 2 0 1", bus_req, outstanding, inst_addr_ok, stallreq_if); end
    next_cycle();
    bus_data_ok = 1; settle();
    checks++; if (bus_req !== 1'b0 || inst_data_ok !== 1'b1) begin errors++; $display("FAIL full_pop_bubble got req %b idok %b exp 0 1", bus_req, inst_data_ok); end
    next_cycle();
    bus_data_ok = 0; settle();
    checks++; if (outstanding !== 3'd1 || bus_req !== 1'b1 || inst_addr_ok !== 1'b1)
      begin errors++; $display("FAIL full_reopen got out %0d req %b iok %b exp 1 1 1", outstanding, bus_req, inst_addr_ok); end
    next_cycle();
    inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
    next_cycle();
    next_cycle();
    bus_data_ok = 0; settle();
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL full_drain got %0d exp 0", outstanding); end
  endtask

  task automatic test_write();
    do_reset();
    data_req = 1; data_wr = 1; data_wstrb = 4'b0011; data_addr = 32'h1FAF0000; data_wdata = 32'h1234; bus_addr_ok = 1; settle();
    checks++; if (bus_wr !== 1'b1 || bus_wstrb !== 4'b0011 || bus_addr !== 32'h1FAF0000 || bus_wdata !== 32'h1234)
      begin errors++; $display("FAIL write_bus got wr %b strb %b addr %h wdata %h exp 1 0011 1faf0000 00001234", bus_wr, bus_wstrb, bus_addr, bus_wdata); end
    checks++; if (data_addr_ok !== 1'b1 || stallreq_mem !== 1'b0) begin errors++; $display("FAIL write_accept got ok %b stall %b exp 1 0", data_addr_ok, stallreq_mem); end
    next_cycle();
    idle_inputs(); settle();
    checks++; if (outstanding !== 3'd1 || stallreq_mem !== 1'b0) begin errors++; $display("FAIL write_wait got out %0d stall %b exp 1 0", outstanding, stallreq_mem); end
    bus_data_ok = 1; settle();
    checks++; if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0) begin errors++; $display("FAIL write_ack got ddok %b idok %b exp 1 0", data_data_ok, inst_data_ok); end
    next_cycle();
    bus_data_ok = 0;
  endtask

  task automatic test_resp_err_and_reset();
    do_reset();
    bus_data_ok = 1; bus_rdata = 32'hDEADBEEF; settle();
    checks++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin errors++; $display("FAIL err_no_pulse got idok %b ddok %b exp 0 0", inst_data_ok, data_data_ok); end
    next_cycle();
    bus_data_ok = 0; settle();
    checks++; if (resp_err !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", resp_err); end
    next_cycle();
    settle();
    checks++; if (resp_err !== 1'b1 || outstanding !== 3'd0) begin errors++; $display("FAIL err_hold got err %b out %0d exp 1 0", resp_err, outstanding); end
    inst_req = 1; bus_addr_ok = 1;
    next_cycle();
    next_cycle();
    inst_req = 0; bus_addr_ok = 0; settle();
    checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL burst_fill got %0d exp 2", outstanding); end
    rst = 1; settle();
    checks++; if (outstanding !== 3'd0 || resp_err !== 1'b0) begin errors++; $display("FAIL mid_reset got out %0d err %b exp 0 0", outstanding, resp_err); end
    next_cycle();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    rst = 0;
    test_single_fetch();
`ifdef ARB_RR_EN
    test_round_robin();
`else
    test_priority();
`endif
    test_max_outstanding();
    test_write();
    test_resp_err_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
